// File: rtl/reg_file_onehot_wr.sv
// 32-entry register file with one-hot write select, x0 hardwired to zero and sticky bad-select flag.
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module reg_file_onehot_wr #(
    parameter int unsigned NO_OF_REGS = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = $clog2(NO_OF_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [NO_OF_REGS-1:0] wr_sel_onehot,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [ADDR_W-1:0]     rs1_addr,
    input  logic [ADDR_W-1:0]     rs2_addr,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    output logic                  sel_err,
    output logic [15:0]           wr_count
);

    localparam int unsigned CNT_W = 16;

    logic [DATA_W-1:0] regs_q [NO_OF_REGS];
    logic              sel_valid_c;
    logic [ADDR_W-1:0] wr_idx_c;
    logic              commit_c;
    logic              bad_sel_c;

    // A single set bit: non-zero and clearing the lowest set bit leaves nothing.
    assign sel_valid_c = (wr_sel_onehot != '0) &&
                         ((wr_sel_onehot & (wr_sel_onehot - NO_OF_REGS'(1))) == '0);

    // Encode the (assumed one-hot) select into an index.
    always_comb begin
        wr_idx_c = '0;
        for (int i = 0; i < int'(NO_OF_REGS); i++) begin
            if (wr_sel_onehot[i]) begin
                wr_idx_c = ADDR_W'(i);
            end
        end
    end

    // Writes aimed at x0 are dropped quietly and do not count.
    assign commit_c  = wr_en && sel_valid_c && (wr_idx_c != '0);
    assign bad_sel_c = wr_en && !sel_valid_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NO_OF_REGS); i++) begin
                regs_q[i] <= '0;
            end
            sel_err  <= 1'b0;
            wr_count <= '0;
        end else begin
            if (commit_c) begin
                regs_q[wr_idx_c] <= wr_data;
                if (wr_count != {CNT_W{1'b1}}) begin
                    wr_count <= wr_count + CNT_W'(1);
                end
            end
            if (bad_sel_c) begin
                sel_err <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic bypass_c;
    assign bypass_c = !rst && commit_c;
`endif

    // Combinational read ports; address 0 always reads as zero.
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
        if (bypass_c && (rs1_addr == wr_idx_c)) begin
            rs1_data = wr_data;
        end
        if (bypass_c && (rs2_addr == wr_idx_c)) begin
            rs2_data = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file_onehot_wr.sv
// Randomized self-checking bench for reg_file_onehot_wr against an array-based reference model.
module tb_reg_file_onehot_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        sel_err;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic        m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    reg_file_onehot_wr #(.NO_OF_REGS(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_sel_onehot(wr_sel),
        .wr_data      (wr_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .sel_err      (sel_err),
        .wr_count     (wr_count)
    );

    // Expected read value for the current (pre-edge) inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!rst && wr_en && $countones(wr_sel) == 1 && int'(a) == $clog2(wr_sel))
            return wr_data;
`endif
        return m_regs[a];
    endfunction

    // Apply the spec's edge rules to the model, then advance one edge.
    task automatic tick();
        int k;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_err = 1'b0;
            m_cnt = 0;
        end else if (wr_en) begin
            if ($countones(wr_sel) == 1) begin
                k = $clog2(wr_sel);
                if (k != 0) begin
                    m_regs[k] = wr_data;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_sel = 32'h0; wr_data = 32'h0;
    endtask

    task automatic write(input int k, input logic [31:0] d);
        rst = 1'b0; wr_en = 1'b1; wr_sel = 32'h1 << k; wr_data = d;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rs1_addr = 5'd5; rs2_addr = 5'd31; #1;
        checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL reset_rs1 got=%h exp=0", rs1_data); end
        checks++; if (rs2_data !== 32'h0) begin failures++; $display("FAIL reset_rs2 got=%h exp=0", rs2_data); end
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sel_err); end
        checks++; if (wr_count !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", wr_count); end
    endtask

    task automatic test_basic();
        write(5, 32'hDEAD_BEEF);
        rs1_addr = 5'd5; #1;
        checks++; if (rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_r5 got=%h exp=deadbeef", rs1_data); end
        checks++; if (wr_count !== 16'd1) begin failures++; $display("FAIL basic_cnt1 got=%0d exp=1", wr_count); end
        write(31, 32'h1234_5678);
        rs2_addr = 5'd31; #1;
        checks++; if (rs2_data !== 32'h1234_5678) begin failures++; $display("FAIL basic_r31 got=%h exp=12345678", rs2_data); end
        checks++; if (wr_count !== 16'd2) begin failures++; $display("FAIL basic_cnt2 got=%0d exp=2", wr_count); end
        rs1_addr = 5'd31; #1;
        checks++; if (rs1_data !== 32'h1234_5678) begin failures++; $display("FAIL basic_same got=%h exp=12345678", rs1_data); end
    endtask

    task automatic test_x0();
        write(0, 32'hFFFF_FFFF);
        rs1_addr = 5'd0; #1;
        checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL x0_read got=%h exp=0", rs1_data); end
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL x0_err got=%b exp=0", sel_err); end
        checks++; if (wr_count !== 16'd2) begin failures++; $display("FAIL x0_cnt got=%0d exp=2", wr_count); end
    endtask

    task automatic test_invalid();
        write(4, 32'h0000_0444);
        rst = 1'b0; wr_en = 1'b1; wr_sel = 32'h0000_0030; wr_data = 32'hAAAA_AAAA;
        tick(); idle();
        rs1_addr = 5'd4; rs2_addr = 5'd5; #1;
        checks++; if (rs1_data !== 32'h0000_0444) begin failures++; $display("FAIL inv_r4 got=%h exp=444", rs1_data); end
        checks++; if (rs2_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL inv_r5 got=%h exp=deadbeef", rs2_data); end
        checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL inv_err got=%b exp=1", sel_err); end
        checks++; if (wr_count !== 16'd3) begin failures++; $display("FAIL inv_cnt got=%0d exp=3", wr_count); end
        tick(); tick();
        checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL inv_sticky got=%b exp=1", sel_err); end
        do_reset();
        wr_en = 1'b1; wr_sel = 32'h0; tick(); idle();
        checks++; if (sel_err !== 1'b1) begin failures++; $display("FAIL zero_sel_err got=%b exp=1", sel_err); end
        do_reset();
        wr_en = 1'b0; wr_sel = 32'h0000_0030; wr_data = 32'hAAAA_AAAA; tick();
        wr_sel = 32'h0; tick(); idle();
        rs1_addr = 5'd5; #1;
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL dis_err got=%b exp=0", sel_err); end
        checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL dis_r5 got=%h exp=0", rs1_data); end
    endtask

    task automatic test_rdw();
        logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h2;
`else
        exp_pre = 32'h1;
`endif
        write(7, 32'h1);
        rst = 1'b0; wr_en = 1'b1; wr_sel = 32'h1 << 7; wr_data = 32'h2; rs1_addr = 5'd7; #1;
        checks++; if (rs1_data !== exp_pre) begin failures++; $display("FAIL rdw_pre got=%h exp=%h", rs1_data, exp_pre); end
        tick(); idle(); #1;
        checks++; if (rs1_data !== 32'h2) begin failures++; $display("FAIL rdw_post got=%h exp=2", rs1_data); end
    endtask

    task automatic test_reset_priority();
        wr_en = 1'b1; wr_sel = 32'h0000_0030; tick(); idle();
        rst = 1'b1; wr_en = 1'b1; wr_sel = 32'h1 << 3; wr_data = 32'h55;
        tick(); idle();
        rs1_addr = 5'd3; rs2_addr = 5'd7; #1;
        checks++; if (rs1_data !== 32'h0) begin failures++; $display("FAIL rstpri_r3 got=%h exp=0", rs1_data); end
        checks++; if (rs2_data !== 32'h0) begin failures++; $display("FAIL rstpri_r7 got=%h exp=0", rs2_data); end
        checks++; if (wr_count !== 16'h0) begin failures++; $display("FAIL rstpri_cnt got=%h exp=0", wr_count); end
        checks++; if (sel_err !== 1'b0) begin failures++; $display("FAIL rstpri_err got=%b exp=0", sel_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            wr_sel = 32'h1 << (1 + (i % 31)); wr_data = i;
            tick();
        end
        idle(); #1;
        checks++; if (wr_count !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", wr_count); end
        for (int i = 0; i < 3; i++) begin
            write(9, 32'hC0DE_0000 + i);
            checks++; if (wr_count !== 16'hFFFF) begin failures++; $display("FAIL sat_%0d got=%h exp=ffff", i, wr_count); end
        end
        rs1_addr = 5'd9; #1;
        checks++; if (rs1_data !== 32'hC0DE_0002) begin failures++; $display("FAIL sat_r9 got=%h exp=c0de0002", rs1_data); end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = $urandom;
            case ($urandom_range(0, 9))
                6:       wr_sel = 32'h0;
                7:       wr_sel = $urandom;
                8:       wr_sel = 32'h1;
                9:       wr_sel = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
                default: wr_sel = 32'h1 << $urandom_range(1, 31);
            endcase
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(rs1_addr);
            e2 = exp_rd(rs2_addr);
            checks++; if (rs1_data !== e1) begin failures++; $display("FAIL rnd_rs1 n=%0d a=%0d got=%h exp=%h", n, rs1_addr, rs1_data, e1); end
            checks++; if (rs2_data !== e2) begin failures++; $display("FAIL rnd_rs2 n=%0d a=%0d got=%h exp=%h", n, rs2_addr, rs2_data, e2); end
            checks++; if (sel_err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, sel_err, m_err); end
            checks++; if (wr_count !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, wr_count, m_cnt); end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_err = 1'b0; m_cnt = 0;
        idle(); rs1_addr = 5'd0; rs2_addr = 5'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_x0();
        test_invalid();
        test_rdw();
        test_reset_priority();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
